// File: rtl/object_draw_ctrl_pkg.sv
// Shared types and default geometry for the object draw controller.
package object_draw_pkg;

    typedef enum logic [1:0] {IDLE, READ, PLOT, DONE} draw_state_t;

    localparam int unsigned N_DEF  = 3;
    localparam int unsigned XS_DEF = 4;
    localparam int unsigned YS_DEF = 4;
    localparam int unsigned NX_DEF = 8;
    localparam int unsigned NY_DEF = 7;

endpackage

// File: rtl/object_draw_ctrl_scan_counter.sv
// Raster scan counters over a 2^XS x 2^YS object; xc runs fastest.
module object_scan_counter #(
    parameter int unsigned XS = 4,
    parameter int unsigned YS = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          advance,
    output logic [XS-1:0] xc,
    output logic [YS-1:0] yc,
    output logic          last
);

    assign last = (xc == '1) && (yc == '1);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            xc <= '0;
            yc <= '0;
        end else if (advance) begin
            xc <= xc + 1'b1;
            if (xc == '1)
                yc <= yc + 1'b1;
        end
    end

endmodule

// File: rtl/object_draw_ctrl.sv
// Scans an object ROM one pixel per READ/PLOT pair and issues VGA plot writes at origin (x0, y0).
// Optional macro OBJECT_TRANSPARENT_EN: skip pixels whose ROM colour equals TRANSP (draw mode only).
module object_draw_ctrl
    import object_draw_pkg::*;
#(
    parameter int unsigned n      = N_DEF,
    parameter int unsigned XS     = XS_DEF,
    parameter int unsigned YS     = YS_DEF,
    parameter int unsigned nX     = NX_DEF,
    parameter int unsigned nY     = NY_DEF,
    parameter logic [n-1:0] TRANSP = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             erase,
    input  logic [nX-1:0]    x0,
    input  logic [nY-1:0]    y0,
    input  logic [n-1:0]     bg_colour,
    output logic [XS+YS-1:0] mem_addr,
    input  logic [n-1:0]     mem_q,
    output logic             plot,
    input  logic             plot_ready,
    output logic [nX-1:0]    vga_x,
    output logic [nY-1:0]    vga_y,
    output logic [n-1:0]     vga_colour,
    output logic             busy,
    output logic             done
);

    draw_state_t       state, next_state;
    logic              erase_l;
    logic [nX-1:0]     x0_l;
    logic [nY-1:0]     y0_l;
    logic              clear, advance, last, transparent;
    logic [XS-1:0]     xc;
    logic [YS-1:0]     yc;

    object_scan_counter #(.XS(XS), .YS(YS)) u_scan (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .advance (advance),
        .xc      (xc),
        .yc      (yc),
        .last    (last)
    );

`ifdef OBJECT_TRANSPARENT_EN
    assign transparent = !erase_l && (mem_q == TRANSP);
`else
    logic unused_transp;
    assign unused_transp = ^TRANSP;
    assign transparent   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            erase_l <= 1'b0;
            x0_l    <= '0;
            y0_l    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && start) begin
                erase_l <= erase;
                x0_l    <= x0;
                y0_l    <= y0;
            end
        end
    end

    always_comb begin
        next_state = state;
        clear      = 1'b0;
        advance    = 1'b0;
        plot       = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                clear      = 1'b1;
                next_state = READ;
            end
            READ: next_state = PLOT;
            PLOT: begin
                // Transparent pixels advance without a write and ignore plot_ready.
                plot = !transparent;
                if (transparent || plot_ready) begin
                    advance    = 1'b1;
                    next_state = last ? DONE : READ;
                end
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign mem_addr   = {yc, xc};
    assign vga_x      = x0_l + nX'(xc);
    assign vga_y      = y0_l + nY'(yc);
    assign vga_colour = erase_l ? bg_colour : mem_q;

endmodule

// File: tb/tb_object_draw_ctrl.sv
// Self-checking bench for object_draw_ctrl against a raster-order pixel list model.
module tb_object_draw_ctrl;

    localparam int W = 16, H = 16, NPIX = 256;
`ifdef OBJECT_TRANSPARENT_EN
    localparam int OPAQUE = 216;
`else
    localparam int OPAQUE = 256;
`endif

    logic       clock = 1'b0;
    logic       reset, start, erase, plot_ready;
    logic [7:0] x0;
    logic [6:0] y0;
    logic [2:0] bg_colour, mem_q, vga_colour;
    logic [7:0] mem_addr, vga_x;
    logic [6:0] vga_y;
    logic       plot, busy, done;

    always #5 clock = ~clock;

    object_draw_ctrl #(.n(3), .XS(4), .YS(4), .nX(8), .nY(7), .TRANSP(3'd0)) dut (
        .clock(clock), .reset(reset), .start(start), .erase(erase),
        .x0(x0), .y0(y0), .bg_colour(bg_colour), .mem_addr(mem_addr),
        .mem_q(mem_q), .plot(plot), .plot_ready(plot_ready), .vga_x(vga_x),
        .vga_y(vga_y), .vga_colour(vga_colour), .busy(busy), .done(done)
    );

    logic [2:0] rom [NPIX];
    always @(posedge clock) mem_q <= rom[mem_addr];

    int checks = 0, errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] x0;
        logic [6:0] y0;
        logic       erase;
        logic [2:0] bg;
        bit         rnd_ready;
        bit         spurious;
        int         exp_plots;
    } scan_vec_t;

    typedef struct { int x; int y; int c; } pix_t;
    pix_t exp_q[$];

    task automatic build_model(input scan_vec_t v);
        int c;
        exp_q.delete();
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                c = v.erase ? int'(v.bg) : int'(rom[y*W + x]);
`ifdef OBJECT_TRANSPARENT_EN
                if (!v.erase && c == 0) continue;
`endif
                exp_q.push_back('{(int'(v.x0) + x) % 256, (int'(v.y0) + y) % 128, c});
            end
    endtask

    task automatic run_scan(input scan_vec_t v, input int abort_at, input bit hold_start);
        int cyc, accepted, done_cyc, px, py, pc;
        bit have_prev;
        pix_t e;
        build_model(v);
        @(negedge clock);
        x0 = v.x0; y0 = v.y0; erase = v.erase; bg_colour = v.bg;
        start = 1'b1; plot_ready = 1'b1;
        @(posedge clock); #1;
        start = hold_start;
        cyc = 0; accepted = 0; done_cyc = -1; have_prev = 0;
        px = 0; py = 0; pc = 0;
        while (cyc < 6000) begin
            @(negedge clock);
            cyc++;
            plot_ready = v.rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (v.spurious) start = 1'($urandom_range(0, 1));
            if (have_prev) begin
                check("stall_plot", int'(plot), 1);
                check("stall_x", int'(vga_x), px);
                check("stall_y", int'(vga_y), py);
                check("stall_colour", int'(vga_colour), pc);
            end
            have_prev = 0;
            if (plot) begin
                if (plot_ready) begin
                    if (exp_q.size() == 0) check("extra_pixel", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        check("pix_x", int'(vga_x), e.x);
                        check("pix_y", int'(vga_y), e.y);
                        check("pix_colour", int'(vga_colour), e.c);
                    end
                    accepted++;
                    if (accepted == abort_at) return;
                end else begin
                    have_prev = 1;
                    px = int'(vga_x); py = int'(vga_y); pc = int'(vga_colour);
                end
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
        end
        start = hold_start;
        check("done_seen", int'(done_cyc > 0), 1);
        check("plot_count", accepted, v.exp_plots);
        check("pixels_left", exp_q.size(), 0);
        if (!v.rnd_ready) check("done_cycle", done_cyc, 513);
        if (!hold_start) begin
            @(negedge clock);
            check("done_width", int'(done), 0);
            check("idle_busy", int'(busy), 0);
        end
    endtask

    scan_vec_t vecs[5];
    int cyc;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NPIX; i++) rom[i] = 3'($urandom_range(1, 7));
        for (int i = 0; i < 40; i++) rom[i*6] = 3'd0;

        vecs[0] = '{8'd10,  7'd20,  1'b0, 3'd0, 1'b0, 1'b0, OPAQUE};
        vecs[1] = '{8'd10,  7'd20,  1'b1, 3'd0, 1'b0, 1'b0, NPIX};
        vecs[2] = '{8'd50,  7'd115, 1'b0, 3'd0, 1'b1, 1'b0, OPAQUE};
        vecs[3] = '{8'd155, 7'd3,   1'b0, 3'd0, 1'b0, 1'b1, OPAQUE};
        vecs[4] = '{8'd200, 7'd60,  1'b1, 3'd5, 1'b1, 1'b1, NPIX};

        reset = 1'b1; start = 1'b0; erase = 1'b0; plot_ready = 1'b1;
        x0 = '0; y0 = '0; bg_colour = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_plot", int'(plot), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_vga_x", int'(vga_x), 0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) run_scan(vecs[i], -1, 1'b0);

        // Reset in the middle of a scan, then a full clean scan.
        run_scan(vecs[0], 100, 1'b0);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_plot", int'(plot), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_addr", int'(mem_addr), 0);
        reset = 1'b0;
        run_scan(vecs[0], -1, 1'b0);

        // Start held high across DONE -> IDLE restarts immediately.
        run_scan(vecs[0], -1, 1'b1);
        @(negedge clock);
        check("hold_done_off", int'(done), 0);
        @(negedge clock);
        check("hold_busy", int'(busy), 1);
        check("hold_read_plot", int'(plot), 0);
        start = 1'b0;
        @(negedge clock);
        check("hold_first_x", int'(vga_x), 10);
        check("hold_first_y", int'(vga_y), 20);
        cyc = 2;
        while (!done && cyc < 2000) begin
            @(negedge clock);
            cyc++;
        end
        check("hold_done_cycle", cyc, 513);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
